// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the receive path and its sub-blocks.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      DONE
   } rx_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 1250;
   localparam int DATA_BITS            = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs that idle high (serial lines, keypad, buttons).
module sync2 (
   input  logic clk,
   input  logic nRst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, start-glitch rejection and framing-error pulse.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | timing to mid start bit, rejecting glitches
// DATA   | sampling 8 data bits LSB first at mid-bit
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit
// DONE   | one cycle carrying the rx_ready / error pulse
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       rx_serial,
   output logic [7:0] rx_byte,
   output logic       rx_ready,
   output logic       framing_err,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       busy
);

   localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

   rx_state_t              state, state_nxt;
   logic                   rx_s;
   logic [CNT_W-1:0]       clk_cnt;
   logic [2:0]             bit_idx;
   logic [DATA_BITS-1:0]   shift_reg;
   logic                   stop_ok;
   logic                   par_ok;
   logic                   half_tick, bit_tick;

   sync2 u_sync (
      .clk  (clk),
      .nRst (nRst),
      .d    (rx_serial),
      .q    (rx_s)
   );

   assign half_tick = (clk_cnt == HALF_M1);
   assign bit_tick  = (clk_cnt == BIT_M1);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (!rx_s) state_nxt = START;
         START: if (half_tick) state_nxt = rx_s ? IDLE : DATA;
         DATA: begin
            if (bit_tick && bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (bit_tick) state_nxt = STOP;
`endif
         STOP:  if (bit_tick) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bit timing and data capture; clk_cnt restarts at every sample point.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         rx_byte   <= '0;
         stop_ok   <= 1'b0;
         par_ok    <= 1'b1;
      end else begin
         case (state)
            START: begin
               if (half_tick) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  par_ok  <= 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_tick) begin
                  shift_reg[bit_idx] <= rx_s;
                  clk_cnt            <= '0;
                  bit_idx            <= bit_idx + 3'd1;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (bit_tick) begin
                  par_ok  <= (rx_s == ^shift_reg);
                  clk_cnt <= '0;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
`endif
            STOP: begin
               if (bit_tick) begin
                  stop_ok <= rx_s;
                  clk_cnt <= '0;
                  if (rx_s && par_ok) rx_byte <= shift_reg;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            default: clk_cnt <= '0;
         endcase
      end
   end

   always_comb begin
      busy        = (state != IDLE);
      rx_ready    = (state == DONE) && stop_ok && par_ok;
      framing_err = (state == DONE) && !stop_ok;
`ifdef UART_RX_PARITY_EN
      parity_err  = (state == DONE) && stop_ok && !par_ok;
`endif
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16; also covers the UART_RX_PARITY_EN build.
`timescale 1ns/1ps
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       nRst;
   logic       rx_serial;
   logic [7:0] rx_byte;
   logic       rx_ready;
   logic       framing_err;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
   localparam int EXP_LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
   localparam int EXP_LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .nRst        (nRst),
      .rx_serial   (rx_serial),
      .rx_byte     (rx_byte),
      .rx_ready    (rx_ready),
      .framing_err (framing_err),
`ifdef UART_RX_PARITY_EN
      .parity_err  (parity_err),
`endif
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   int ready_cnt, ferr_cnt, perr_cnt, both_cnt, busy_cyc, ready_cyc;
   logic [7:0] byte_log [2];

   always @(posedge clk) cycle++;

   always @(negedge clk) begin
      if (rx_ready) begin
         if (ready_cnt < 2) byte_log[ready_cnt] = rx_byte;
         ready_cnt++;
         ready_cyc = cycle;
      end
      if (framing_err) ferr_cnt++;
      if (rx_ready && framing_err) both_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) perr_cnt++;
`endif
      if (busy) busy_cyc++;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic clear_counts();
      ready_cnt = 0; ferr_cnt = 0; perr_cnt = 0; both_cnt = 0; busy_cyc = 0;
      ready_cyc = -1;
      byte_log[0] = 8'h00; byte_log[1] = 8'h00;
   endtask

   task automatic send_bit(input logic b);
      rx_serial = b;
      repeat (CPB) @(negedge clk);
   endtask

   // par_flip inverts the even-parity bit in the parity build.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                             output int start_cyc);
      start_cyc = cycle;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ par_flip);
`else
      if (par_flip) start_cyc = cycle;
`endif
      send_bit(stop);
      rx_serial = 1'b1;
   endtask

   task automatic idle(input int n);
      rx_serial = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_ready;
      int         exp_ferr;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs [6];
   int   sc;

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
      vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
      vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
      vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
      vecs[4] = '{8'h81, 1'b0, 0, 1, 8'hFF};
      vecs[5] = '{8'h5A, 1'b1, 1, 0, 8'h5A};

      nRst = 1'b0;
      rx_serial = 1'b1;
      clear_counts();
      repeat (4) @(negedge clk);
      chk("reset_rx_byte", rx_byte, 8'h00);
      chk("reset_rx_ready", rx_ready, 0);
      chk("reset_framing_err", framing_err, 0);
      chk("reset_busy", busy, 0);
      nRst = 1'b1;
      idle(4);

      for (int v = 0; v < 6; v++) begin
         clear_counts();
         send_frame(vecs[v].data, vecs[v].stop, 1'b0, sc);
         idle(24);
         chk($sformatf("v%0d_ready_cnt", v), ready_cnt, vecs[v].exp_ready);
         chk($sformatf("v%0d_ferr_cnt", v), ferr_cnt, vecs[v].exp_ferr);
         chk($sformatf("v%0d_rx_byte", v), rx_byte, vecs[v].exp_byte);
         chk($sformatf("v%0d_busy_idle", v), busy, 0);
         chk($sformatf("v%0d_overlap", v), both_cnt, 0);
         chk($sformatf("v%0d_perr_cnt", v), perr_cnt, 0);
         if (vecs[v].exp_ready == 1)
            chk($sformatf("v%0d_latency_ok", v),
                int'((ready_cyc - sc) >= EXP_LAT - 1 && (ready_cyc - sc) <= EXP_LAT + 1), 1);
      end

      // back-to-back frames, single stop bit
      clear_counts();
      send_frame(8'h48, 1'b1, 1'b0, sc);
      send_frame(8'h49, 1'b1, 1'b0, sc);
      idle(24);
      chk("b2b_ready_cnt", ready_cnt, 2);
      chk("b2b_byte0", byte_log[0], 8'h48);
      chk("b2b_byte1", byte_log[1], 8'h49);
      chk("b2b_ferr_cnt", ferr_cnt, 0);

      // short low glitch on idle line
      clear_counts();
      rx_serial = 1'b0;
      repeat (5) @(negedge clk);
      idle(30);
      chk("glitch_pulses", ready_cnt + ferr_cnt + perr_cnt, 0);
      chk("glitch_busy_window", int'(busy_cyc > 0 && busy_cyc <= 10), 1);
      chk("glitch_busy_idle", busy, 0);

      // reset in the middle of data bit 4 of 8'hFF
      clear_counts();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      repeat (CPB / 2) @(negedge clk);
      nRst = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_rx_byte", rx_byte, 8'h00);
      nRst = 1'b1;
      idle(CPB * 8);
      chk("midrst_no_pulse", ready_cnt + ferr_cnt + perr_cnt, 0);
      send_frame(8'h0F, 1'b1, 1'b0, sc);
      idle(24);
      chk("after_rst_ready_cnt", ready_cnt, 1);
      chk("after_rst_rx_byte", rx_byte, 8'h0F);

`ifdef UART_RX_PARITY_EN
      clear_counts();
      send_frame(8'h07, 1'b1, 1'b1, sc);
      idle(24);
      chk("par_bad_perr_cnt", perr_cnt, 1);
      chk("par_bad_ready_cnt", ready_cnt, 0);
      chk("par_bad_rx_byte", rx_byte, 8'h0F);
      clear_counts();
      send_frame(8'h07, 1'b1, 1'b0, sc);
      idle(24);
      chk("par_good_perr_cnt", perr_cnt, 0);
      chk("par_good_ready_cnt", ready_cnt, 1);
      chk("par_good_rx_byte", rx_byte, 8'h07);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that sits directly downstream of the transmit path (uart_tx feeding tx_serial) on the far end of the link.
- Recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from an idle-high serial line.
- Presents each received byte with a one-cycle valid strobe to the game-logic/message stage.
- Flags framing errors and rejects start-bit glitches.

Parameters:
CLKS_PER_BIT, 1250, clk cycles per serial bit; must match the transmitter's setting; legal range 4..65535.
CNT_W, $clog2(CLKS_PER_BIT), width of the bit-timing counter (derived; not overridden).

Ports:
clk  input  1  system clock
nRst  input  1  asynchronous active-low reset
rx_serial  input  1  asynchronous serial line, idle high
rx_byte  output  8  last correctly framed byte; holds until the next good frame
rx_ready  output  1  one-cycle pulse; rx_byte is valid and new
framing_err  output  1  one-cycle pulse; stop bit sampled low
busy  output  1  high while a frame is in progress (any state other than IDLE)

Behaviour:
- Reset and clocking:
  - One clock; nRst is asynchronous, active-low.
  - Reset values: rx_byte=8'h00, rx_ready=0, framing_err=0, busy=0, state=IDLE, counters=0, synchroniser flops=1.
- Input synchronisation:
  - rx_serial passes through a 2-flop synchroniser; rx_s is the synchronised value.
  - All timing below is relative to rx_s.
- States: IDLE, START, DATA, STOP, DONE.
- IDLE:
  - Stays while rx_s=1.
  - rx_s=0 -> START; clk_cnt=0.
- START:
  - clk_cnt increments each cycle.
  - When clk_cnt = CLKS_PER_BIT/2 - 1 (integer division), sample rx_s (mid start bit).
  - Sample 0 -> DATA, clk_cnt=0, bit_idx=0.
  - Sample 1 -> IDLE; glitch rejected, no output pulse.
- DATA:
  - When clk_cnt = CLKS_PER_BIT - 1, sample rx_s into shift_reg[bit_idx] and clear clk_cnt.
  - bit_idx runs 0..7. After the sample with bit_idx=7 -> STOP; otherwise bit_idx++.
  - Every sample therefore lands at mid-bit.
- STOP:
  - When clk_cnt = CLKS_PER_BIT - 1, sample rx_s.
  - Sample 1: rx_byte <= shift_reg; rx_ready=1 in the next cycle.
  - Sample 0: framing_err=1 in the next cycle; rx_byte is unchanged.
  - Either way -> DONE.
- DONE:
  - Lasts exactly one cycle, during which the pulse is high; then -> IDLE.
  - No wait for the end of the stop bit, so back-to-back frames with a single stop bit are received.
- Latency: rx_ready rises 2 (synchroniser) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the falling start edge at the rx_serial pin (±1 cycle synchroniser uncertainty).
- Line held low after a framing error:
  - IDLE sees rx_s=0 and re-enters START.
  - If the line is still low at mid-bit, a frame is received. This is intended break behaviour; each resulting frame pulses framing_err.
- rx_ready and framing_err are never high in the same cycle.
- There is no back-pressure. The consumer must capture rx_byte on rx_ready. rx_byte is stable for at least 10*CLKS_PER_BIT cycles afterwards.
- Reset mid-frame: returns immediately to the reset values; the partial frame is discarded with no pulse.
- Counter width: clk_cnt is CNT_W bits and never exceeds CLKS_PER_BIT-1. bit_idx is 3 bits.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An extra state PARITY sits between DATA and STOP and samples one even-parity bit at mid-bit.
  - Adds output parity_err (1 bit, one-cycle pulse, reset 0).
  - Parity mismatch with a good stop bit: parity_err pulses, rx_ready is suppressed, rx_byte is unchanged.
  - Frame length becomes 11 bits; latency grows by CLKS_PER_BIT.
- Undefined: the port and state do not exist; 8N1 only.
- The transmitter must be built with the same setting.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP, DONE}.
  - localparam DEFAULT_CLKS_PER_BIT = 1250.
  - localparam DATA_BITS = 8.
- Natural sub-module: sync2 (2-flop synchroniser, reset value 1), reusable for the keypad/button inputs.

Test Plan:
- CLKS_PER_BIT=16; drive frame for 8'hA5 (stop=1) -> exactly one rx_ready pulse, rx_byte=8'hA5, framing_err stays 0, busy low after DONE.
- Loopback: uart_tx driven with tx_byte 8'h48, 8'h49 back-to-back into rx_serial -> rx_ready twice, rx_byte 8'h48 then 8'h49, no gap frames.
- Frame 8'h3C with stop bit driven 0 -> framing_err one pulse, no rx_ready, rx_byte retains previous 8'hA5.
- 5-cycle low glitch on idle line (less than CLKS_PER_BIT/2) -> back to IDLE, no pulses, busy high for at most 10 cycles.
- nRst asserted during DATA bit 4 of 8'hFF, then a clean 8'h0F frame -> no pulse for the aborted frame; rx_ready with rx_byte=8'h0F.
- With UART_RX_PARITY_EN: 8'h07 with parity bit 0 (wrong) -> parity_err pulse, no rx_ready; with parity 1 -> rx_ready, rx_byte=8'h07.
